r22_bf2ii_sdf: RTL and testbench
================================

R22_BF2II_SDF -- requirements
Module: r22_bf2ii_sdf

Interface
REQ-001 Parameter HWIDTH, default 16, signed width of each real/imag component; packed word width DWIDTH = 2*HWIDTH, {re, im}.
REQ-002 Parameter DEPTH_LOG, default 3, log2 of the feedback delay length N = 2^DEPTH_LOG; legal range 0..10.
REQ-003 Parameter ROUND_EN, default 1: 1 = round-half-up before every right shift; 0 = truncate.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 i_data  in  DWIDTH  input sample {re, im}, two's complement.
REQ-007 i_valid  in  1  input sample qualifier; the stage advances only on cycles with i_valid=1.
REQ-008 i_inverse  in  1  0 = forward (multiply by -j), 1 = inverse (multiply by +j); sampled at frame start.
REQ-009 i_scale  in  1  1 = divide butterfly results by 2, 0 = unscaled with saturation; sampled at frame start.
REQ-010 o_data  out  DWIDTH  registered output sample.
REQ-011 o_valid  out  1  registered output qualifier.
REQ-012 o_frame_start  out  1  pulses with o_valid on the first output of each 4N-sample frame.

Function
REQ-013 Internal delay line SHALL hold N complex words and advance one position per accepted input; no external FIFO ports.
REQ-014 Frame counter c, width DEPTH_LOG+2, SHALL increment per accepted input and wrap 4N-1 -> 0; p = c[DEPTH_LOG], q = c[DEPTH_LOG+1].
REQ-015 Mode bits m_inv, m_scale SHALL be latched from i_inverse/i_scale on an accepted input with c=0 and held for the rest of the frame.
REQ-016 States: FILL (p=0) and BFLY (p=1), decoded from c; no other state is required.
REQ-017 FILL: delay line write = x, result = delay head.
REQ-018 BFLY: b = x if q=0; b = -j*x = (im, -re) if q=1 and m_inv=0; b = +j*x = (-im, re) if q=1 and m_inv=1.
REQ-019 BFLY: result = head + b; delay line write = head - b; both computed at HWIDTH+1 bits.
REQ-020 m_scale=1: sum and difference SHALL be arithmetic-shifted right by 1 (rounded per ROUND_EN) before use; cannot overflow.
REQ-021 m_scale=0: sum and difference SHALL saturate to [-2^(HWIDTH-1), 2^(HWIDTH-1)-1] per component.
REQ-022 Negation of -2^(HWIDTH-1) in the ±j multiply SHALL saturate to 2^(HWIDTH-1)-1.
REQ-023 Latency: o_data/o_valid SHALL update on the clock edge following the accepted input (1 cycle); the sample-to-delayed-difference path is N accepted inputs plus 1 cycle.
REQ-024 o_valid SHALL be 1 on the cycle after each accepted input once the stage is primed (N inputs accepted since reset), else 0.
REQ-025 Outputs are suppressed for the first N accepted inputs after reset; primed flag SHALL then stay set until reset.
REQ-026 With i_valid=0, c, delay line, o_data and mode bits SHALL hold and o_valid SHALL be 0; gaps of any length SHALL not corrupt results.
REQ-027 o_frame_start SHALL be 1 exactly when o_valid=1 and the producing input had c=N (first BFLY of a frame).
REQ-028 No backpressure: every input with i_valid=1 SHALL be accepted.

Reset
REQ-029 On reset: c=0, primed=0, m_inv=0, m_scale=1, o_data=0, o_valid=0, o_frame_start=0.
REQ-030 Delay-line contents need not be reset; they SHALL never reach o_data while primed=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the first valid after reset is frame sample 0 in FILL.

Verification
REQ-032 HWIDTH=16, DEPTH_LOG=1, scale=1, fwd; 8 inputs (100,0) back-to-back -> outputs from input 2: (100,0),(100,0),(0,0),(0,0),(50,-50),(50,-50); then next frame's first two outputs (50,50),(50,50).
REQ-033 Same stream with i_inverse=1 -> BFLY q=1 outputs (50,50), stored differences (50,-50).
REQ-034 scale=0, inputs (30000,0) and (30000,0) in one BFLY pair -> sum saturates to (32767,0), difference (0,0).
REQ-035 q=1 input (-32768,0), forward, scale=0, head (0,0) -> b=(0,32767), output (0,32767).
REQ-036 Random i_valid gaps (50% duty) on 1000 random frames -> output stream identical to gap-free golden R2^2 BF2II model.
REQ-037 Reset asserted at c=5 mid-stream -> o_valid=0 next cycle; after reset, first N inputs produce no output; o_frame_start on input N.

Source files
------------

// File: rtl/r22_bf2ii_sdf_if.sv
// r22_bf2ii_sdf_if: streaming complex-sample bus into and out of a BF2II SDF stage
interface r22_bf2ii_sdf_if #(
    parameter int HWIDTH = 16
);
    logic [2*HWIDTH-1:0] i_data;
    logic                i_valid;
    logic                i_inverse;
    logic                i_scale;
    logic [2*HWIDTH-1:0] o_data;
    logic                o_valid;
    logic                o_frame_start;

    modport master (
        output i_data, i_valid, i_inverse, i_scale,
        input  o_data, o_valid, o_frame_start
    );

    modport slave (
        input  i_data, i_valid, i_inverse, i_scale,
        output o_data, o_valid, o_frame_start
    );
endinterface

// File: rtl/r22_bf2ii_sdf.sv
// r22_bf2ii_sdf: radix-2^2 BF2II single-path delay-feedback butterfly stage with trivial +/-j twiddle
module r22_bf2ii_sdf #(
    parameter int HWIDTH    = 16,
    parameter int DEPTH_LOG = 3,
    parameter bit ROUND_EN  = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    r22_bf2ii_sdf_if.slave bus
);
    localparam int DWIDTH = 2 * HWIDTH;
    localparam int N      = 1 << DEPTH_LOG;
    localparam int CW     = DEPTH_LOG + 2;
    localparam int AW     = (DEPTH_LOG == 0) ? 1 : DEPTH_LOG;
    localparam logic signed [HWIDTH-1:0] SMAX = {1'b0, {(HWIDTH-1){1'b1}}};
    localparam logic signed [HWIDTH-1:0] SMIN = {1'b1, {(HWIDTH-1){1'b0}}};
    localparam logic signed [HWIDTH:0]   WMAX = {2'b00, {(HWIDTH-1){1'b1}}};
    localparam logic signed [HWIDTH:0]   WMIN = {2'b11, {(HWIDTH-1){1'b0}}};
    localparam logic signed [HWIDTH:0]   RND  = {{HWIDTH{1'b0}}, ROUND_EN};

    typedef enum logic {FILL = 1'b0, BFLY = 1'b1} state_t;

    logic [CW-1:0]     c_q, c_d;
    logic              primed_q, primed_d;
    logic              m_inv_q, m_inv_d;
    logic              m_scale_q, m_scale_d;
    logic [DWIDTH-1:0] o_data_q, o_data_d;
    logic              o_valid_q, o_valid_d;
    logic              o_fs_q, o_fs_d;
    logic [DWIDTH-1:0] mem_q [N];
    logic [AW-1:0]     ptr;
    logic              acc;
    state_t            state;
    logic [DWIDTH-1:0] head, wr_data, result, bfly_sum, bfly_diff;
    logic signed [HWIDTH-1:0] h_re, h_im, x_re, x_im, b_re, b_im;
    logic signed [HWIDTH:0]   s_re, s_im, d_re, d_im;

    // Negating the most negative value has no representation, so clamp it to the positive limit
    function automatic logic signed [HWIDTH-1:0] neg_sat(input logic signed [HWIDTH-1:0] v);
        return (v == SMIN) ? SMAX : -v;
    endfunction

    // Bring a widened sum/difference back to HWIDTH: halve (optionally rounded) or saturate
    function automatic logic signed [HWIDTH-1:0] fit(input logic signed [HWIDTH:0] s, input logic scale);
        logic signed [HWIDTH:0] r;
        r = (s + RND) >>> 1;
        if (scale) return r[HWIDTH-1:0];
        return (s > WMAX) ? SMAX : (s < WMIN) ? SMIN : s[HWIDTH-1:0];
    endfunction

    // Slot index is the low counter bits: reading then rewriting the same slot yields an N-sample delay
    generate
        if (DEPTH_LOG == 0) begin : g_ptr_one
            assign ptr = '0;
        end else begin : g_ptr_n
            assign ptr = c_q[AW-1:0];
        end
    endgenerate

    // Butterfly datapath: twiddle the new sample by 1 or +/-j, then form head+b and head-b
    always_comb begin
        state     = state_t'(c_q[DEPTH_LOG]);
        head      = mem_q[ptr];
        h_re      = head[DWIDTH-1:HWIDTH];
        h_im      = head[HWIDTH-1:0];
        x_re      = bus.i_data[DWIDTH-1:HWIDTH];
        x_im      = bus.i_data[HWIDTH-1:0];
        b_re      = !c_q[DEPTH_LOG+1] ? x_re : m_inv_q ? neg_sat(x_im) : x_im;
        b_im      = !c_q[DEPTH_LOG+1] ? x_im : m_inv_q ? x_re : neg_sat(x_re);
        s_re      = {h_re[HWIDTH-1], h_re} + {b_re[HWIDTH-1], b_re};
        s_im      = {h_im[HWIDTH-1], h_im} + {b_im[HWIDTH-1], b_im};
        d_re      = {h_re[HWIDTH-1], h_re} - {b_re[HWIDTH-1], b_re};
        d_im      = {h_im[HWIDTH-1], h_im} - {b_im[HWIDTH-1], b_im};
        bfly_sum  = {fit(s_re, m_scale_q), fit(s_im, m_scale_q)};
        bfly_diff = {fit(d_re, m_scale_q), fit(d_im, m_scale_q)};
        result    = (state == BFLY) ? bfly_sum : head;
        wr_data   = (state == BFLY) ? bfly_diff : bus.i_data;
    end

    // Next state: every valid input advances the frame; modes latch on frame sample 0
    always_comb begin
        acc       = bus.i_valid;
        c_d       = acc ? c_q + CW'(1) : c_q;
        m_inv_d   = (acc && c_q == '0) ? bus.i_inverse : m_inv_q;
        m_scale_d = (acc && c_q == '0) ? bus.i_scale : m_scale_q;
        primed_d  = primed_q | (acc && c_q == CW'(N - 1));
        o_valid_d = acc & primed_q;
        o_fs_d    = acc & primed_q & (c_q == CW'(N));
        o_data_d  = (acc & primed_q) ? result : o_data_q;
    end

    // Control and output registers; the delay line is left unreset since it is refilled before use
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q       <= '0;
            primed_q  <= 1'b0;
            m_inv_q   <= 1'b0;
            m_scale_q <= 1'b1;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_fs_q    <= 1'b0;
        end else begin
            c_q       <= c_d;
            primed_q  <= primed_d;
            m_inv_q   <= m_inv_d;
            m_scale_q <= m_scale_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_fs_q    <= o_fs_d;
        end
    end

    // Delay-line write on each accepted sample
    always_ff @(posedge clk) begin
        if (acc) mem_q[ptr] <= wr_data;
    end

    assign bus.o_data        = o_data_q;
    assign bus.o_valid       = o_valid_q;
    assign bus.o_frame_start = o_fs_q;
endmodule

// File: tb/tb_r22_bf2ii_sdf.sv
// tb_r22_bf2ii_sdf: scoreboard bench feeding hand-computed vectors through an N=2 BF2II stage
module tb_r22_bf2ii_sdf;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    r22_bf2ii_sdf_if #(.HWIDTH(16)) bus ();
    r22_bf2ii_sdf #(.HWIDTH(16), .DEPTH_LOG(1), .ROUND_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [31:0] x; bit inv; bit scl; bit exp; logic [31:0] ed; bit efs; } vec_t;
    typedef struct { logic [31:0] d; bit fs; } exp_t;

    vec_t        tv[$];
    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] hold_exp = '0;

    function automatic logic [31:0] cx(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic void add(input int xr, xi, input bit inv, scl, exp, input int er, ei, input bit efs);
        tv.push_back('{cx(xr, xi), inv, scl, exp, cx(er, ei), efs});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
        end
    endtask

    task automatic send(input int i);
        @(posedge clk); #1;
        bus.i_data    = tv[i].x;
        bus.i_valid   = 1'b1;
        bus.i_inverse = tv[i].inv;
        bus.i_scale   = tv[i].scl;
        if (tv[i].exp) sb.push_back('{tv[i].ed, tv[i].efs});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.i_valid   = 1'b0;
            bus.i_data    = $urandom();
            bus.i_inverse = 1'($urandom_range(1));
            bus.i_scale   = 1'($urandom_range(1));
        end
    endtask

    task automatic play(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps && $urandom_range(1) == 1) idle($urandom_range(3, 1));
            send(i);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset       = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = cx(1234, -1234);
        @(posedge clk); #1;
        check("o_valid after reset", 32'(bus.o_valid), 0);
        check("o_frame_start after reset", 32'(bus.o_frame_start), 0);
        check("o_data after reset", bus.o_data, 0);
        reset       = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    // Monitor: every presented output pops one expectation; idle cycles must hold o_data
    initial forever begin
        @(negedge clk);
        if (reset) hold_exp = '0;
        else if (bus.o_valid) begin
            if (sb.size() == 0) check("unexpected o_valid", 32'(bus.o_valid), 0);
            else begin
                mon_e = sb.pop_front();
                check("o_data", bus.o_data, mon_e.d);
                check("o_frame_start", 32'(bus.o_frame_start), 32'(mon_e.fs));
                hold_exp = mon_e.d;
            end
        end else begin
            check("o_frame_start idle", 32'(bus.o_frame_start), 0);
            check("o_data hold", bus.o_data, hold_exp);
        end
    end

    initial begin
        bus.i_data    = '0;
        bus.i_valid   = 1'b0;
        bus.i_inverse = 1'b0;
        bus.i_scale   = 1'b0;
        // frame 0: forward, scaled; later entries carry opposite mode bits that must be ignored
        add(100, 0, 0, 1, 0, 0, 0, 0);
        add(100, 0, 1, 0, 0, 0, 0, 0);
        add(100, 0, 1, 0, 1, 100, 0, 1);
        add(100, 0, 1, 0, 1, 100, 0, 0);
        add(100, 0, 1, 0, 1, 0, 0, 0);
        add(100, 0, 1, 0, 1, 0, 0, 0);
        add(100, 0, 1, 0, 1, 50, -50, 0);
        add(100, 0, 1, 0, 1, 50, -50, 0);
        // frame 1: inverse, scaled
        add(100, 0, 1, 1, 1, 50, 50, 0);
        add(100, 0, 0, 0, 1, 50, 50, 0);
        add(100, 0, 0, 0, 1, 100, 0, 1);
        add(100, 0, 0, 0, 1, 100, 0, 0);
        add(100, 0, 0, 0, 1, 0, 0, 0);
        add(100, 0, 0, 0, 1, 0, 0, 0);
        add(100, 0, 0, 0, 1, 50, 50, 0);
        add(100, 0, 0, 0, 1, 50, 50, 0);
        // frame 2: forward, unscaled; positive saturation and -j of the most negative value
        add(30000, 0, 0, 0, 1, 50, -50, 0);
        add(30000, 0, 1, 1, 1, 50, -50, 0);
        add(30000, 0, 1, 1, 1, 32767, 0, 1);
        add(30000, 0, 1, 1, 1, 32767, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(-32768, 0, 1, 1, 1, 0, 32767, 0);
        add(-32768, 0, 1, 1, 1, 0, 32767, 0);
        // frame 3: forward, unscaled; negative saturation of sum and difference
        add(-30000, -20000, 0, 0, 1, 0, -32767, 0);
        add(-30000, 5, 1, 1, 1, 0, -32767, 0);
        add(-30000, 20000, 1, 1, 1, -32768, 0, 1);
        add(5, -30000, 1, 1, 1, -29995, -29995, 0);
        add(0, 0, 1, 1, 1, 0, -32768, 0);
        add(0, 0, 1, 1, 1, -30005, 30005, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        // frame 4: forward, scaled; abandoned by reset at c=5
        add(7, 7, 0, 1, 1, 0, 0, 0);
        add(7, 7, 1, 0, 1, 0, 0, 0);
        add(7, 7, 1, 0, 1, 7, 7, 1);
        add(7, 7, 1, 0, 1, 7, 7, 0);
        add(7, 7, 1, 0, 1, 0, 0, 0);
        // after reset: refill, then round-half-up on odd and negative values
        add(10, 20, 0, 1, 0, 0, 0, 0);
        add(30, 40, 1, 0, 0, 0, 0, 0);
        add(1, 2, 1, 0, 1, 6, 11, 1);
        add(3, 4, 1, 0, 1, 17, 22, 0);
        add(-3, 5, 1, 0, 1, 5, 9, 0);
        add(0, 0, 1, 0, 1, 14, 18, 0);
        add(1, -1, 1, 0, 1, -2, 2, 0);
        add(-5, 0, 1, 0, 1, 0, 3, 0);
        add(0, 0, 0, 1, 1, -1, 3, 0);
        add(0, 0, 0, 1, 1, 0, -2, 0);

        idle(3);
        check("reset o_valid", 32'(bus.o_valid), 0);
        check("reset o_frame_start", 32'(bus.o_frame_start), 0);
        check("reset o_data", bus.o_data, 0);
        reset = 1'b0;

        play(0, 36, 1'b0);
        idle(2);
        check("scoreboard drained before reset", sb.size(), 0);
        pulse_reset();
        play(37, 46, 1'b0);
        idle(2);
        check("scoreboard drained after refill", sb.size(), 0);
        pulse_reset();
        play(0, 9, 1'b1);
        idle(3);
        check("scoreboard drained after gapped run", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
